up_down_step_decoder: RTL and testbench

//   Receive-side decoder for the up/down counter stream: accepts successive count samples over a valid/ready

---
 rtl/up_down_step_decoder.sv | 126 ++++++++++++
 tb/tb_up_down_step_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/up_down_step_decoder.sv
// up_down_step_decoder: recovers up/down direction from a stream of count samples, flags non-unit steps,
// tracks lock status and keeps saturating run/error statistics.
//   Optional feature macro: HOLD_ALLOW_EN (delta==0 becomes a legal hold instead of an illegal step).
//   Ports:
//     clk, reset (async, active-high), clear (sync)
//     in_valid/in_ready/in_count : sample input handshake
//     dir_valid, dir_up          : legal-step pulse and held direction
//     step_err                   : illegal-step pulse
//     locked                     : high while LOCKED
//     up_run, down_run, err_cnt  : saturating statistics
module up_down_step_decoder #(
  parameter int WIDTH    = 4,
  parameter int RUN_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_count,
  output logic             dir_valid,
  output logic             dir_up,
  output logic             step_err,
  output logic             locked,
  output logic [RUN_W-1:0] up_run,
  output logic [RUN_W-1:0] down_run,
  output logic [RUN_W-1:0] err_cnt
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, delta;
  logic [GW-1:0] good_q, good_d;
  logic dir_valid_q, dir_valid_d, dir_up_q, dir_up_d, step_err_q, step_err_d;
  logic [RUN_W-1:0] up_run_q, up_run_d, down_run_q, down_run_d, err_cnt_q, err_cnt_d;
  logic accept, is_up, is_dn, hold;
  assign in_ready  = state_q != ERROR;
  assign accept    = in_valid && in_ready;
  assign delta     = in_count - prev_q;
  assign is_up     = delta == WIDTH'(1);
  assign is_dn     = delta == {WIDTH{1'b1}};
`ifdef HOLD_ALLOW_EN
  assign hold      = delta == '0;
`else
  assign hold      = 1'b0;
`endif
  assign locked    = state_q == LOCKED;
  assign dir_valid = dir_valid_q;
  assign dir_up    = dir_up_q;
  assign step_err  = step_err_q;
  assign up_run    = up_run_q;
  assign down_run  = down_run_q;
  assign err_cnt   = err_cnt_q;
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    dir_valid_d = 1'b0;
    step_err_d  = 1'b0;
    dir_up_d    = dir_up_q;
    up_run_d    = up_run_q;
    down_run_d  = down_run_q;
    err_cnt_d   = err_cnt_q;
    if (clear) begin
      state_d    = IDLE;
      good_d     = '0;
      dir_up_d   = 1'b0;
      up_run_d   = '0;
      down_run_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (state_q == ERROR) state_d = IDLE;
      if (accept) begin
        prev_d = in_count;
        if (state_q == IDLE) begin
          state_d = TRACK;
          good_d  = '0;
        end else if (is_up || is_dn) begin
          dir_valid_d = 1'b1;
          dir_up_d    = is_up;
          up_run_d    = is_up ? (&up_run_q ? up_run_q : up_run_q + RUN_W'(1)) : '0;
          down_run_d  = is_dn ? (&down_run_q ? down_run_q : down_run_q + RUN_W'(1)) : '0;
          if (state_q == TRACK) begin
            good_d  = good_q + GW'(1);
            state_d = (good_d == GW'(LOCK_CNT)) ? LOCKED : TRACK;
          end
        end else if (hold) begin
          dir_valid_d = 1'b1;
        end else begin
          step_err_d = 1'b1;
          err_cnt_d  = &err_cnt_q ? err_cnt_q : err_cnt_q + RUN_W'(1);
          up_run_d   = '0;
          down_run_d = '0;
          state_d    = ERROR;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      good_q      <= '0;
      dir_valid_q <= 1'b0;
      dir_up_q    <= 1'b0;
      step_err_q  <= 1'b0;
      up_run_q    <= '0;
      down_run_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      dir_valid_q <= dir_valid_d;
      dir_up_q    <= dir_up_d;
      step_err_q  <= step_err_d;
      up_run_q    <= up_run_d;
      down_run_q  <= down_run_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_up_down_step_decoder.sv
// tb_up_down_step_decoder: directed self-checking bench for up_down_step_decoder.
module tb_up_down_step_decoder;
  logic clk = 1'b0;
  logic reset, clear, in_valid;
  logic [3:0] in_count;
  logic in_ready, dir_valid, dir_up, step_err, locked;
  logic [7:0] up_run, down_run, err_cnt;
  logic s_in_ready, s_dir_valid, s_dir_up, s_step_err, s_locked;
  logic [1:0] s_up_run, s_down_run, s_err_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  up_down_step_decoder #(.WIDTH(4), .RUN_W(8), .LOCK_CNT(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .dir_valid(dir_valid), .dir_up(dir_up), .step_err(step_err),
    .locked(locked), .up_run(up_run), .down_run(down_run), .err_cnt(err_cnt)
  );
  up_down_step_decoder #(.WIDTH(4), .RUN_W(2), .LOCK_CNT(2)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_count(in_count), .dir_valid(s_dir_valid), .dir_up(s_dir_up), .step_err(s_step_err),
    .locked(s_locked), .up_run(s_up_run), .down_run(s_down_run), .err_cnt(s_err_cnt)
  );
  task automatic do_reset();
    clear = 1'b0;
    in_valid = 1'b0;
    in_count = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic drive(input logic [3:0] v);
    in_valid = 1'b1;
    in_count = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_count = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", in_ready); end
    checks++; if ({dir_valid, dir_up, step_err, locked} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {dir_valid, dir_up, step_err, locked}); end
    checks++; if ({up_run, down_run, err_cnt} !== 24'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=000000", {up_run, down_run, err_cnt}); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_back_to_back();
    drive(4'h3);
    checks++; if (dir_valid !== 1'b0) begin failures++; $display("FAIL b2b_ref_dv got=%0b exp=0", dir_valid); end
    drive(4'h4);
    checks++; if ({dir_valid, dir_up, locked} !== 3'b110) begin failures++; $display("FAIL b2b_s4 got=%b exp=110", {dir_valid, dir_up, locked}); end
    drive(4'h5);
    checks++; if ({dir_valid, dir_up, locked} !== 3'b111) begin failures++; $display("FAIL b2b_s5 got=%b exp=111", {dir_valid, dir_up, locked}); end
    drive(4'h6);
    checks++; if ({dir_valid, dir_up, locked} !== 3'b111) begin failures++; $display("FAIL b2b_s6 got=%b exp=111", {dir_valid, dir_up, locked}); end
    checks++; if ({up_run, down_run, err_cnt} !== {8'd3, 8'd0, 8'd0}) begin failures++; $display("FAIL b2b_cnt got=%h exp=030000", {up_run, down_run, err_cnt}); end
    @(negedge clk);
    checks++; if ({dir_valid, dir_up} !== 2'b01) begin failures++; $display("FAIL b2b_pulse got=%b exp=01", {dir_valid, dir_up}); end
  endtask
  task automatic test_wrap();
    logic [3:0] seq [7];
    logic [6:0] exp_up;
    logic [7:0] exp_dn_run;
    seq = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h0, 4'hF, 4'hE};
    exp_up = 7'b0001110;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(seq[i]);
      checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL wrap_err[%0d] got=%0b exp=0", i, step_err); end
      if (i > 0) begin
        checks++; if ({dir_valid, dir_up} !== {1'b1, exp_up[i]}) begin failures++; $display("FAIL wrap_dir[%0d] got=%b exp=1%0b", i, {dir_valid, dir_up}, exp_up[i]); end
      end
    end
    exp_dn_run = 8'd3;
    checks++; if ({up_run, down_run, err_cnt, locked} !== {8'd0, exp_dn_run, 8'd0, 1'b1}) begin failures++; $display("FAIL wrap_cnt got=%h/%h/%h/%b exp=00/03/00/1", up_run, down_run, err_cnt, locked); end
  endtask
  task automatic test_illegal_jump();
    do_reset();
    drive(4'h3);
    drive(4'h4);
    drive(4'h5);
    drive(4'h9);
    checks++; if ({step_err, dir_valid, locked, in_ready} !== 4'b1000) begin failures++; $display("FAIL jump_flags got=%b exp=1000", {step_err, dir_valid, locked, in_ready}); end
    checks++; if ({err_cnt, up_run, down_run} !== {8'd1, 8'd0, 8'd0}) begin failures++; $display("FAIL jump_cnt got=%h exp=010000", {err_cnt, up_run, down_run}); end
    checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL jump_dirup_held got=%0b exp=1", dir_up); end
    @(negedge clk);
    checks++; if ({step_err, in_ready, locked} !== 3'b010) begin failures++; $display("FAIL jump_recover got=%b exp=010", {step_err, in_ready, locked}); end
    drive(4'hA);
    checks++; if (dir_valid !== 1'b0) begin failures++; $display("FAIL jump_newref_dv got=%0b exp=0", dir_valid); end
    drive(4'hB);
    drive(4'hC);
    checks++; if ({locked, up_run, err_cnt} !== {1'b1, 8'd2, 8'd1}) begin failures++; $display("FAIL jump_relock got=%b/%h/%h exp=1/02/01", locked, up_run, err_cnt); end
  endtask
  task automatic test_repeat();
    do_reset();
    drive(4'h6);
    drive(4'h7);
    drive(4'h7);
`ifdef HOLD_ALLOW_EN
    checks++; if ({dir_valid, step_err, dir_up} !== 3'b101) begin failures++; $display("FAIL hold_flags got=%b exp=101", {dir_valid, step_err, dir_up}); end
    checks++; if ({up_run, err_cnt} !== {8'd1, 8'd0}) begin failures++; $display("FAIL hold_cnt got=%h exp=0100", {up_run, err_cnt}); end
`else
    checks++; if ({dir_valid, step_err} !== 2'b01) begin failures++; $display("FAIL rep_flags got=%b exp=01", {dir_valid, step_err}); end
    checks++; if ({up_run, err_cnt} !== {8'd0, 8'd1}) begin failures++; $display("FAIL rep_cnt got=%h exp=0001", {up_run, err_cnt}); end
`endif
    @(negedge clk);
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 7; i++) drive(4'(i));
    checks++; if (s_up_run !== 2'd3) begin failures++; $display("FAIL sat_up got=%0d exp=3", s_up_run); end
    checks++; if (up_run !== 8'd6) begin failures++; $display("FAIL sat_up_wide got=%0d exp=6", up_run); end
    drive(4'h5);
    checks++; if ({s_down_run, s_up_run, s_dir_up} !== {2'd1, 2'd0, 1'b0}) begin failures++; $display("FAIL sat_down got=%0d/%0d/%0b exp=1/0/0", s_down_run, s_up_run, s_dir_up); end
  endtask
  task automatic test_clear();
    do_reset();
    drive(4'h3);
    drive(4'h4);
    drive(4'h5);
    clear = 1'b1;
    drive(4'h8);
    clear = 1'b0;
    checks++; if ({locked, dir_valid, dir_up, step_err, in_ready} !== 5'b00001) begin failures++; $display("FAIL clr_flags got=%b exp=00001", {locked, dir_valid, dir_up, step_err, in_ready}); end
    checks++; if ({up_run, down_run, err_cnt} !== 24'h0) begin failures++; $display("FAIL clr_cnt got=%h exp=000000", {up_run, down_run, err_cnt}); end
    drive(4'h9);
    checks++; if (dir_valid !== 1'b0) begin failures++; $display("FAIL clr_ref_dv got=%0b exp=0", dir_valid); end
    drive(4'hA);
    checks++; if ({dir_valid, locked, up_run} !== {2'b10, 8'd1}) begin failures++; $display("FAIL clr_step got=%b/%h exp=10/01", {dir_valid, locked}, up_run); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    drive(4'h1);
    drive(4'h2);
    drive(4'h3);
    #2 reset = 1'b1;
    #1;
    checks++; if ({locked, dir_up, up_run} !== {2'b00, 8'd0}) begin failures++; $display("FAIL mid_rst got=%b/%h exp=00/00", {locked, dir_up}, up_run); end
    @(negedge clk);
    reset = 1'b0;
    drive(4'h4);
    checks++; if (dir_valid !== 1'b0) begin failures++; $display("FAIL mid_ref_dv got=%0b exp=0", dir_valid); end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_illegal_jump();
    test_repeat();
    test_saturation();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
